ram_stream_reader: RTL and testbench

Read-side master for the 16-bit single-port feature/weight RAM. A start pulse with a base address and a length makes the block issue sequential read addresses to the RAM. It absorbs the RAM's one-cycle registered-address read latency and presents the words as a valid/ready stream with a last flag to the CNN datapath. A small internal FIFO decouples the RAM from downstream backpressure.

---
 rtl/ram_stream_pkg.sv | 15 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/ram_stream_reader.sv | 130 +++++++++++++
 tb/tb_ram_stream_reader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_pkg.sv
// Shared types and default sizes for the RAM stream reader and its output buffer.
package ram_stream_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_CNT_W      = $clog2(DEF_FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a first-word-fall-through head; pointers wrap naturally
// because DEPTH is a power of two.
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_pop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign count  = count_q;
  assign dout   = mem[rd_ptr_q];
  assign do_pop = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Sequential RAM read master: issues addresses, absorbs the one-cycle RAM latency and
// streams the words out through a credit-protected FIFO with a last flag.
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;
  logic              issue, pop;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, fifo_full;
  logic [CNT_W:0]    credit_used;

  assign m_valid  = !fifo_empty;
  assign pop      = m_valid && m_ready;
  assign m_last   = m_valid && (beat_cnt_q == ADDR_W'(1));
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign ram_addr = ram_addr_q;

  // Words already buffered plus the one still inside the RAM; a same-cycle pop is ignored.
  assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    if (pop) beat_cnt_d = beat_cnt_q - 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d     = RUN;
            ram_addr_d  = base_addr;
            issue_cnt_d = length;
            beat_cnt_d  = length;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if ((issue_cnt_q != '0) && (credit_used < (CNT_W+1)'(FIFO_DEPTH))) begin
          issue       = 1'b1;
          ram_addr_d  = ram_addr_q + 1'b1;
          issue_cnt_d = issue_cnt_q - 1'b1;
          if (issue_cnt_q == ADDR_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    inflight_d = issue;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ram_addr_q  <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
    end
  end

  // The word registered by the RAM last cycle is on ram_q now and is pushed this edge.
  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (ram_q),
    .pop   (pop),
    .dout  (m_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(inflight_q && fifo_full))
        else $error("ram_stream_reader: push into full output FIFO");
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader; the RAM stand-in returns addr+0x100 one cycle late.
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] length = '0;
  logic [15:0] ram_addr;
  logic [15:0] ram_q = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= ram_addr + 16'h0100;

  ram_stream_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .ram_addr  (ram_addr),
    .ram_q     (ram_q),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (m_valid !== 1'b0)    $display("FAIL reset_valid got %b want 0", m_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0)       $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0)       $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++; if (m_last !== 1'b0)     $display("FAIL reset_last got %b want 0", m_last); else n_pass++;
    n_checks++; if (ram_addr !== 16'h0) $display("FAIL reset_addr got %h want 0000", ram_addr); else n_pass++;
    #3 rst = 1'b0;
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h0010; length = 16'd4;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k <= 4) begin
        n_checks++;
        if (ram_addr !== 16'h0010 + 16'(k - 1)) $display("FAIL basic_addr k=%0d got %h want %h", k, ram_addr, 16'h0010 + 16'(k - 1));
        else n_pass++;
      end
      if (k >= 3 && k <= 6) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 16'h0110 + 16'(k - 3))
          $display("FAIL basic_data k=%0d got v=%b d=%h want v=1 d=%h", k, m_valid, m_data, 16'h0110 + 16'(k - 3));
        else n_pass++;
      end
      n_checks++; if (m_last !== 1'(k == 6)) $display("FAIL basic_last k=%0d got %b", k, m_last); else n_pass++;
      n_checks++; if (done !== 1'(k == 7))   $display("FAIL basic_done k=%0d got %b", k, done); else n_pass++;
      if (k == 1 || k == 7) begin
        n_checks++; if (busy !== 1'(k == 1)) $display("FAIL basic_busy k=%0d got %b", k, busy); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    int got = 0;
    bit seen_done = 0;
    m_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h0010; length = 16'd8;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k >= 3) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 16'h0110) $display("FAIL bp_hold k=%0d got v=%b d=%h want v=1 d=0110", k, m_valid, m_data);
        else n_pass++;
      end
    end
    n_checks++; if (ram_addr !== 16'h0014) $display("FAIL bp_issued got addr %h want 0014", ram_addr); else n_pass++;
    m_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (m_valid && m_ready) begin
        n_checks++;
        if (m_data !== 16'h0110 + got[15:0] || m_last !== 1'(got == 7))
          $display("FAIL bp_word %0d got d=%h l=%b want d=%h", got, m_data, m_last, 16'h0110 + got[15:0]);
        else n_pass++;
        got++;
      end
      @(posedge clk); #1;
      if (done) begin seen_done = 1; break; end
    end
    n_checks++; if (got != 8 || !seen_done) $display("FAIL bp_count got %0d words done=%0b want 8 done=1", got, seen_done); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_addr [4];
    logic [15:0] exp_data [4];
    exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    exp_data = '{16'h00FE, 16'h00FF, 16'h0100, 16'h0101};
    m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'hFFFE; length = 16'd4;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k <= 4) begin
        n_checks++; if (ram_addr !== exp_addr[k-1]) $display("FAIL wrap_addr k=%0d got %h want %h", k, ram_addr, exp_addr[k-1]); else n_pass++;
      end
      if (k >= 3 && k <= 6) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== exp_data[k-3] || m_last !== 1'(k == 6))
          $display("FAIL wrap_data k=%0d got v=%b d=%h l=%b want d=%h", k, m_valid, m_data, m_last, exp_data[k-3]);
        else n_pass++;
      end
    end
    n_checks++; if (done !== 1'b1) $display("FAIL wrap_done got %b want 1", done); else n_pass++;
  endtask

  task automatic test_zero_len();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h0099; length = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0)
      $display("FAIL zero_pulse got done=%b busy=%b valid=%b want 1 0 0", done, busy, m_valid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0)
      $display("FAIL zero_after got done=%b busy=%b valid=%b want 0 0 0", done, busy, m_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int got = 0;
    bit seen_done = 0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h0040; length = 16'd3;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      start = (c == 2);
      if (c == 2) begin base_addr = 16'h0080; length = 16'd10; end
      if (done) begin seen_done = 1; break; end
      if (m_valid && m_ready) begin
        n_checks++;
        if (m_data !== 16'h0140 + got[15:0]) $display("FAIL ign_word %0d got %h want %h", got, m_data, 16'h0140 + got[15:0]);
        else n_pass++;
        got++;
      end
    end
    n_checks++; if (got != 3 || !seen_done) $display("FAIL ign_count got %0d done=%0b want 3 done=1", got, seen_done); else n_pass++;
    n_checks++; if (ram_addr !== 16'h0043 || busy !== 1'b0) $display("FAIL ign_end got addr=%h busy=%b want 0043 0", ram_addr, busy); else n_pass++;
    start = 1'b1; base_addr = 16'h0060; length = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || ram_addr !== 16'h0060) $display("FAIL b2b_start got busy=%b addr=%h want 1 0060", busy, ram_addr); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (m_valid !== 1'b1 || m_data !== 16'h0160 || m_last !== 1'b1)
      $display("FAIL b2b_word got v=%b d=%h l=%b want 1 0160 1", m_valid, m_data, m_last); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b1) $display("FAIL b2b_done got %b want 1", done); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int got = 0;
    int n_done = 0;
    m_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h0010; length = 16'd8;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    n_checks++; if (m_valid !== 1'b1 || busy !== 1'b1) $display("FAIL rmid_pre got v=%b busy=%b want 1 1", m_valid, busy); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (m_valid !== 1'b0)      $display("FAIL rmid_valid got %b want 0", m_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0)         $display("FAIL rmid_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0)         $display("FAIL rmid_done got %b want 0", done); else n_pass++;
    n_checks++; if (ram_addr !== 16'h0000) $display("FAIL rmid_addr got %h want 0000", ram_addr); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    m_ready = 1'b1;
    start = 1'b1; base_addr = 16'h0020; length = 16'd2;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) n_done++;
      if (m_valid && m_ready) begin
        n_checks++;
        if (m_data !== 16'h0120 + got[15:0] || m_last !== 1'(got == 1))
          $display("FAIL rmid_word %0d got d=%h l=%b want d=%h", got, m_data, m_last, 16'h0120 + got[15:0]);
        else n_pass++;
        got++;
      end
    end
    n_checks++; if (got != 2 || n_done != 1) $display("FAIL rmid_count got %0d words %0d done want 2 1", got, n_done); else n_pass++;
  endtask

  task automatic test_random();
    int got = 0;
    int n_last = 0;
    bit seen_done = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h0200; length = 16'd64;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (m_valid && m_ready) begin
        n_checks++;
        if (m_data !== 16'h0300 + got[15:0] || m_last !== 1'(got == 63))
          $display("FAIL rand_word %0d got d=%h l=%b want d=%h", got, m_data, m_last, 16'h0300 + got[15:0]);
        else n_pass++;
        if (m_last) n_last++;
        got++;
      end
      @(posedge clk); #1;
      if (done) begin seen_done = 1; break; end
    end
    n_checks++; if (got != 64 || n_last != 1 || !seen_done)
      $display("FAIL rand_total got %0d words %0d last done=%0b want 64 1 1", got, n_last, seen_done); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
